aes_key_schedule_seq: RTL
=========================

Name: aes_key_schedule_seq

Overview:
- Iterative, clocked AES key-schedule engine for AES-128, AES-192 and AES-256.
- Accepts a cipher key with a start/ready handshake, generates one 32-bit schedule word per cycle per FIPS-197, and stores every round key internally.
- The round-cipher datapath reads any round key by index through a registered read port.
- Successor to the combinational single-round AES-128 expansion: parametrised key size, full-schedule buffering, handshake and status.

Parameters:
- KEY_BITS, 128, cipher key size; legal values 128, 192, 256. Nk = KEY_BITS/32, Nr = Nk+6, NW = 4*(Nr+1), giving 44, 52 or 60 words.
- RIDX_W, 4, width of the round-index port; must hold Nr (max 14).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request expansion; accepted when start && ready
- key_in  in  KEY_BITS  cipher key, sampled on the accept cycle; bits [KEY_BITS-1 -: 32] are w[0]
- ready  out  1  high when idle or done; a new start is accepted
- busy  out  1  high while words are being generated
- keys_valid  out  1  level; all NW words are stored and unchanged since completion
- done  out  1  one-cycle pulse on the first cycle keys_valid is high
- rd_round  in  RIDX_W  round-key index, 0..Nr
- rd_key  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, registered

Behaviour:
- Reset, sampled at a clk edge with rst_n=0:
  - Outputs: ready=1, busy=0, keys_valid=0, done=0, rd_key=0.
  - FSM goes to IDLE; word counter and Rcon register are cleared.
  - Word storage is not cleared; keys_valid gates all reads.
  - Reset mid-expansion aborts the run; no done is produced.
- FSM states are IDLE, EXPAND, DONE.
- IDLE or DONE, start=1:
  - Load w[0..Nk-1] from key_in in one cycle.
  - Set word index i=Nk and rcon=0x01.
  - Next state EXPAND; keys_valid drops the next cycle.
  - A restart from DONE is legal and overwrites the stored keys.
- EXPAND: each cycle compute and write w[i], then i++.
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon). The sequence is 01,02,04,08,10,20,40,80,1b,36.
  - Else if Nk==8 and i mod Nk == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - RotWord is a one-byte left circular rotation. SubWord is four parallel AES S-boxes (sub_byte).
- When w[NW-1] is written, the next state is DONE.
- Latency: with start accepted at edge T, the last word is written at edge T+(NW-Nk). That is 40, 46 or 52 cycles for KEY_BITS 128, 192, 256. keys_valid=1 and done=1 hold after that edge; done clears one cycle later.
- busy=1 exactly in EXPAND. ready = !busy.
- start while busy is ignored: no effect, key_in not sampled.
- Read port:
  - rd_key updates one cycle after rd_round is presented.
  - It returns the stored key when keys_valid=1 and rd_round <= Nr, otherwise 0.
  - Reads are allowed in any state.
- Simultaneous start and rd_round in DONE: rd_key for that cycle reflects the old keys_valid=1. The next cycle returns 0.
- Storage is an NW x 32 array, written one word per cycle, plus a single-cycle Nk-word load. No read-during-write hazard is visible, because reads are gated by keys_valid.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - done exactly 40 cycles after accept.
  - rd_round=0 gives 2b7e151628aed2a6abf7158809cf4f3c.
  - rd_round=1 gives a0fafe1788542cb123a339392a6c7605.
  - rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_round=11 gives 0.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done after 46 cycles.
  - rd_round=12 gives e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done after 52 cycles.
  - rd_round=14 gives fe4890d1e6188d0b046df344706c631e. This exercises the i mod 8 == 4 SubWord path.
- Handshake (128):
  - A second start with a different key at cycle 5 of EXPAND is ignored; the first key's round 10 result is unchanged.
  - A restart from DONE drops keys_valid to 0 and makes rd_key 0 until the new done.
- Reset mid-operation (128): rst_n=0 at cycle 20 of EXPAND gives busy=0, keys_valid=0, rd_key=0 and no done pulse. A fresh start then completes in 40 cycles with correct keys.
- Back-to-back: start held high continuously, two keys in sequence. Every accept happens only when ready=1, and each done pulse is exactly one cycle wide.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key-schedule engine for AES-128/192/256.
// Loads the cipher key in one cycle, then generates one 32-bit schedule word
// per cycle into an internal NW x 32 store. A registered read port returns
// any round key once the whole schedule is complete.
//
// Handshake: a start is accepted on any cycle where start && ready.
// ready is low only while words are being generated (busy), and a start seen
// during that time is dropped without sampling key_in.
module aes_key_schedule_seq #(
    parameter int KEY_BITS = 128,
    parameter int RIDX_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                ready,
    output logic                busy,
    output logic                keys_valid,
    output logic                done,
    input  logic [RIDX_W-1:0]   rd_round,
    output logic [127:0]        rd_key
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int AW = $clog2(NW);

    localparam logic [AW-1:0]     NK_A    = AW'(NK);
    localparam logic [AW-1:0]     LAST_W  = AW'(NW - 1);
    localparam logic [2:0]        NK_LAST = 3'(NK - 1);
    localparam logic [RIDX_W-1:0] NR_IDX  = RIDX_W'(NR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // GF(2^8) multiply by x, modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (x^254, which maps 0 to 0) followed
    // by the affine transform with constant 0x63.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int n = 0; n < 6; n++) r = gf_mul(gf_mul(r, r), x);
        r = gf_mul(r, r);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]),
                sub_byte(w[15:8]),  sub_byte(w[7:0])};
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   i_q, i_d;          // index of the next word to generate
    logic [2:0]      phase_q, phase_d;  // i mod Nk, tracked incrementally
    logic [7:0]      rcon_q, rcon_d;
    logic            done_q, done_d;
    logic [127:0]    rd_key_q, rd_key_d;
    logic [31:0]     mem_q [NW];

    logic            load;
    logic            we;
    logic [31:0]     w_prev;
    logic [31:0]     w_back;
    logic [31:0]     temp;
    logic [31:0]     w_new;
    logic [AW-1:0]   rd_base;

    assign busy       = (state_q == EXPAND);
    assign ready      = !busy;
    assign keys_valid = (state_q == DONE);
    assign done       = done_q;
    assign rd_key     = rd_key_q;

    // Next-state logic: accept a key when idle/done, generate until last word.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        we      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = EXPAND;
                    load    = 1'b1;
                end
            end
            EXPAND: begin
                we = 1'b1;
                if (i_q == LAST_W) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Schedule datapath: w[i] = w[i-Nk] ^ f(w[i-1]) plus counter/Rcon updates.
    always_comb begin
        w_prev  = mem_q[i_q - AW'(1)];
        w_back  = mem_q[i_q - NK_A];
        temp    = w_prev;
        i_d     = i_q;
        phase_d = phase_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        if (phase_q == 3'd0) begin
            temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && phase_q == 3'd4) begin
            temp = sub_word(w_prev);
        end
        w_new = w_back ^ temp;
        if (load) begin
            i_d     = NK_A;
            phase_d = 3'd0;
            rcon_d  = 8'h01;
        end else if (we) begin
            i_d     = i_q + AW'(1);
            phase_d = (phase_q == NK_LAST) ? 3'd0 : phase_q + 3'd1;
            if (phase_q == 3'd0) rcon_d = xtime(rcon_q);
            done_d  = (i_q == LAST_W);
        end
    end

    // Registered read port: zero unless the schedule is complete and in range.
    always_comb begin
        rd_key_d = '0;
        rd_base  = AW'({rd_round, 2'b00});
        if (keys_valid && rd_round <= NR_IDX) begin
            rd_key_d = {mem_q[rd_base],          mem_q[rd_base + AW'(1)],
                        mem_q[rd_base + AW'(2)], mem_q[rd_base + AW'(3)]};
        end
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            i_q      <= '0;
            phase_q  <= 3'd0;
            rcon_q   <= 8'h00;
            done_q   <= 1'b0;
            rd_key_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            phase_q  <= phase_d;
            rcon_q   <= rcon_d;
            done_q   <= done_d;
            rd_key_q <= rd_key_d;
        end
    end

    // Word store: Nk-word key load on accept, one generated word per cycle.
    // Not cleared by reset; keys_valid gates every read.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (load) begin
                for (int k = 0; k < NK; k++) begin
                    mem_q[k] <= key_in[KEY_BITS-1-32*k -: 32];
                end
            end else if (we) begin
                mem_q[i_q] <= w_new;
            end
        end
    end

endmodule
